lbp_host: RTL
=============

Name: lbp_host

Overview:
- Host-side counterpart of the LBP engine's image interface.
- Accepts a 128x128 8-bit gray image over a streaming load port and stores it internally.
- Raises gray_ready and answers the engine's gray_addr/gray_req reads with zero-latency data, and captures the engine's lbp_valid/lbp_addr/lbp_data result writes.
- On the engine's finish, streams the full result image out over a valid/ready dump port.

Parameters:
- DIM_LOG2, 7, log2 of image side; image is 2^DIM_LOG2 square; address width ADDR_W = 2*DIM_LOG2 (14).
- PIX_W, 8, gray and LBP pixel width.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins image load from IDLE or DONE.
- load_valid  in  1  load pixel present.
- load_data  in  PIX_W  pixel, raster order starting at address 0.
- gray_ready  out  1  image available to engine.
- gray_req  in  1  engine read request.
- gray_addr  in  ADDR_W  engine read address, {row,col}.
- gray_data  out  PIX_W  gray pixel at gray_addr.
- lbp_valid  in  1  result write strobe.
- lbp_addr  in  ADDR_W  result address.
- lbp_data  in  PIX_W  result value.
- finish  in  1  engine done, level.
- dump_valid  out  1  result pixel offered.
- dump_ready  in  1  sink accepts.
- dump_addr  out  ADDR_W  address of offered pixel.
- dump_data  out  PIX_W  result pixel.
- done  out  1  dump complete, level.
- proto_err  out  1  sticky protocol violation.

Behaviour:
- States:
  - IDLE: start -> LOAD.
  - LOAD: after the 2^ADDR_W-th accepted pixel -> SERVE.
  - SERVE: finish -> DUMP.
  - DUMP: last handshake -> DONE.
  - DONE: start -> LOAD.
  - Any state: reset -> IDLE.
- Reset values:
  - State = IDLE.
  - gray_ready, dump_valid, done, proto_err = 0.
  - load counter and dump_addr = 0.
  - gray_data and dump_data are combinational, so they are not reset.
  - Memory contents are not reset.
- LOAD:
  - Each cycle with load_valid=1: gray_mem[load_cnt] <= load_data, res_mem[load_cnt] <= 0, load_cnt++.
  - load_cnt wraps to 0 on the transition to SERVE.
  - Clearing res_mem during load leaves border pixels, which the engine never writes, reading as 0.
- SERVE:
  - gray_ready = 1, registered and asserted the cycle after the state is entered.
  - gray_data = gray_mem[gray_addr] combinationally, independent of gray_req. The engine samples data on the edge after it updates the address.
  - lbp_valid=1 -> res_mem[lbp_addr] <= lbp_data at that edge.
- Simultaneous lbp_valid and finish in the same cycle: the write is captured, then the block enters DUMP.
- DUMP:
  - gray_ready = 0.
  - dump_valid = 1; dump_data = res_mem[dump_addr] combinationally.
  - On dump_valid&&dump_ready, dump_addr++.
  - Under backpressure, dump_addr and dump_data hold stable.
  - The handshake at address 2^ADDR_W-1 -> DONE; dump_valid drops the next cycle and dump_addr wraps to 0.
- DONE: done = 1 until start.
- Ignored inputs, each also setting proto_err:
  - load_valid outside LOAD.
  - lbp_valid or finish outside SERVE.
  - start outside IDLE/DONE.
- proto_err clears only on reset.
- Reset asserted mid-LOAD or mid-DUMP: immediate return to IDLE; partial contents remain and are overwritten by the next load.

Optional Feature:
- Macro: LBP_HOST_CHECKSUM_EN.
- Defined:
  - Adds output checksum [23:0], reset 0, cleared on start.
  - In SERVE, adds lbp_data (zero-extended) on every lbp_valid write.
  - The value is stable from DUMP onward.
- Undefined: the port and accumulator are absent; all other behaviour is identical.

Decomposition:
- Package lbp_pkg holds:
  - DIM_LOG2, ADDR_W, PIX_W.
  - IMG_PIXELS = 2^ADDR_W.
  - LAST_ADDR = IMG_PIXELS-1.
  - Host state enum {IDLE, LOAD, SERVE, DUMP, DONE}.
- Sub-module lbp_img_ram: one synchronous write port and one asynchronous read port, depth IMG_PIXELS. Instantiated twice, for gray_mem and res_mem.

Test Plan:
- Load ramp (pixel i = i[7:0]) -> gray_ready=1 the cycle after the final load; gray_addr=129 gives gray_data=0x81 the same cycle; gray_addr=16254 gives 0x7E.
- In SERVE, lbp_valid at addr 130 with data 0x5A, then finish -> DUMP shows addr 130 = 0x5A, addr 0 = 0x00, addr 16383 = 0x00; done rises after 16384 handshakes.
- In DUMP, dump_ready held low 3 cycles at addr 5 -> dump_addr=5 and dump_data constant; advances to 6 after ready returns.
- lbp_valid (addr 200, 0x33) in the same cycle as finish -> addr 200 dumps 0x33; proto_err stays 0.
- Reset asserted after 500 loaded pixels -> IDLE, gray_ready=0; start plus a full reload completes normally. lbp_valid in IDLE -> proto_err=1 and no memory write.
- With LBP_HOST_CHECKSUM_EN: writes 0xFF, 0x01, 0x80 -> checksum=0x000180 in DUMP.

Source files
------------

// File: rtl/lbp_pkg.sv
`default_nettype none
// lbp_pkg: shared image geometry and host state encoding for the LBP host block.
// Revision: 1.0
package lbp_pkg;

  localparam int DIM_LOG2   = 7;
  localparam int ADDR_W     = 2 * DIM_LOG2;
  localparam int PIX_W      = 8;
  localparam int IMG_PIXELS = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_PIXELS - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SERVE = 3'd2,
    ST_DUMP  = 3'd3,
    ST_DONE  = 3'd4
  } host_state_e;

endpackage
`default_nettype wire

// File: rtl/lbp_img_ram.sv
`default_nettype none
// lbp_img_ram: image-sized RAM, one synchronous write port, one asynchronous read port.
// Revision: 1.0
module lbp_img_ram #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/lbp_host.sv
`default_nettype none
// lbp_host: loads a gray image, serves it to the LBP engine, captures results and dumps them.
// Optional macro LBP_HOST_CHECKSUM_EN adds a 24-bit sum of result writes. Revision: 1.0
module lbp_host
  import lbp_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              load_valid,
  input  logic [PIX_W-1:0]  load_data,
  output logic              gray_ready,
  input  logic              gray_req,
  input  logic [ADDR_W-1:0] gray_addr,
  output logic [PIX_W-1:0]  gray_data,
  input  logic              lbp_valid,
  input  logic [ADDR_W-1:0] lbp_addr,
  input  logic [PIX_W-1:0]  lbp_data,
  input  logic              finish,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [ADDR_W-1:0] dump_addr,
  output logic [PIX_W-1:0]  dump_data,
  output logic              done,
  output logic              proto_err
`ifdef LBP_HOST_CHECKSUM_EN
  ,
  output logic [23:0]       checksum
`endif
);

  host_state_e       r_state;
  host_state_e       w_next;
  logic [ADDR_W-1:0] r_load_cnt;
  logic [ADDR_W-1:0] r_dump_addr;
  logic              r_gray_ready;
  logic              r_dump_valid;
  logic              r_done;
  logic              r_proto_err;

  logic              w_start_ok;
  logic              w_load_acc;
  logic              w_lbp_wr;
  logic              w_dump_hs;
  logic              w_proto;
  logic              w_res_we;
  logic [ADDR_W-1:0] w_res_waddr;
  logic [PIX_W-1:0]  w_res_wdata;
  logic              w_unused;

  // Data is presented combinationally from gray_addr, so the request strobe carries no information.
  assign w_unused = gray_req;

  assign w_start_ok = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_load_acc = load_valid && (r_state == ST_LOAD);
  assign w_lbp_wr   = lbp_valid && (r_state == ST_SERVE);
  assign w_dump_hs  = r_dump_valid && dump_ready;

  assign w_proto = (load_valid && (r_state != ST_LOAD))
                || ((lbp_valid || finish) && (r_state != ST_SERVE))
                || (start && !((r_state == ST_IDLE) || (r_state == ST_DONE)));

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_next = ST_LOAD;
      ST_LOAD:  if (w_load_acc && (r_load_cnt == LAST_ADDR)) w_next = ST_SERVE;
      ST_SERVE: if (finish) w_next = ST_DUMP;
      ST_DUMP:  if (w_dump_hs && (r_dump_addr == LAST_ADDR)) w_next = ST_DONE;
      ST_DONE:  if (start) w_next = ST_LOAD;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_load_cnt   <= '0;
      r_dump_addr  <= '0;
      r_gray_ready <= 1'b0;
      r_dump_valid <= 1'b0;
      r_done       <= 1'b0;
      r_proto_err  <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_gray_ready <= (w_next == ST_SERVE);
      r_dump_valid <= (w_next == ST_DUMP);
      r_done       <= (w_next == ST_DONE);
      if (w_start_ok) begin
        r_load_cnt <= '0;
      end else if (w_load_acc) begin
        r_load_cnt <= r_load_cnt + 1'b1;
      end
      // Natural 14-bit wrap returns the dump pointer to 0 after the last pixel.
      if (w_dump_hs) begin
        r_dump_addr <= r_dump_addr + 1'b1;
      end
      if (w_proto) begin
        r_proto_err <= 1'b1;
      end
    end
  end

  // Result memory is cleared alongside the gray load so unwritten border pixels read 0.
  assign w_res_we    = w_load_acc || w_lbp_wr;
  assign w_res_waddr = w_load_acc ? r_load_cnt : lbp_addr;
  assign w_res_wdata = w_load_acc ? '0 : lbp_data;

  lbp_img_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (PIX_W)
  ) u_gray_mem (
    .clk     (clk),
    .i_we    (w_load_acc),
    .i_waddr (r_load_cnt),
    .i_wdata (load_data),
    .i_raddr (gray_addr),
    .o_rdata (gray_data)
  );

  lbp_img_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (PIX_W)
  ) u_res_mem (
    .clk     (clk),
    .i_we    (w_res_we),
    .i_waddr (w_res_waddr),
    .i_wdata (w_res_wdata),
    .i_raddr (r_dump_addr),
    .o_rdata (dump_data)
  );

  assign gray_ready = r_gray_ready;
  assign dump_valid = r_dump_valid;
  assign dump_addr  = r_dump_addr;
  assign done       = r_done;
  assign proto_err  = r_proto_err;

`ifdef LBP_HOST_CHECKSUM_EN
  logic [23:0] r_checksum;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_checksum <= '0;
    end else if (w_start_ok) begin
      r_checksum <= '0;
    end else if (w_lbp_wr) begin
      r_checksum <= r_checksum + {16'd0, lbp_data};
    end
  end

  assign checksum = r_checksum;
`endif

endmodule
`default_nettype wire
